data_mem_ctrl: RTL and testbench

Bridges the core's combinational data-memory port (en/we/addr/wd in, rd/stall out) to a multi-cycle backing data memory with a valid/ready request channel and a separate read-response channel. It sits directly downstream of the execute/memory stage. It holds that stage with `stall` until each load or store has completed. It also flags out-of-range addresses and lost read responses so that a bad access cannot hang the pipeline.

---
 rtl/data_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl
//  Brief    : Bridges the core's single-cycle data-memory port to a multi-cycle
//             valid/ready backing memory, stalling the core until completion.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH   = 65536,
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int              c_CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [32:0]     c_DEPTH   = 33'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_we;
    logic [31:0]          r_addr;
    logic [31:0]          r_wd;
    logic [31:0]          r_rd;
    logic                 r_err;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_oor;
    logic                 w_timeout;

    // Zero-extended so DEPTH values at the top of the 32-bit range still compare correctly
    assign w_oor     = ({1'b0, addr} >= c_DEPTH);
    assign w_timeout = (r_cnt == c_TIMEOUT);

    assign rd        = r_rd;
    assign err       = r_err;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wd;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        mem_req      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall = en;
                if (en) begin
                    w_state_next = w_oor ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_state_next = r_we ? ST_DONE : ST_RESP;
                end
            end
            ST_RESP: begin
                stall = 1'b1;
                if (mem_rvalid || w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // en still belongs to the instruction that just completed
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we   <= 1'b0;
            r_addr <= 32'd0;
            r_wd   <= 32'd0;
            r_rd   <= 32'd0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_we   <= we;
                        r_addr <= addr;
                        r_wd   <= wd;
                        if (w_oor) begin
                            r_rd  <= 32'd0;
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready && !r_we) begin
                        r_cnt <= '0;
                    end
                end
                ST_RESP: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    // A response in the final waiting cycle still wins over the timeout
                    if (mem_rvalid) begin
                        r_rd <= mem_rdata;
                    end else if (w_timeout) begin
                        r_rd  <= 32'd0;
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_ctrl
//  Brief    : Self-checking bench for data_mem_ctrl with a backing-memory model
//             and a transaction-level reference of latency, data and errors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    localparam int c_DEPTH = 65536;
    localparam int c_TO    = 4;

    logic        clock;
    logic        reset;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    bit [31:0] bmem    [bit [31:0]];
    bit [31:0] ref_mem [bit [31:0]];
    logic [31:0] m_rd;
    logic        m_err;

    data_mem_ctrl #(.DEPTH(c_DEPTH), .TIMEOUT(c_TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .we         (we),
        .addr       (addr),
        .wd         (wd),
        .rd         (rd),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One core access; rdly = extra cycles mem_ready stays low, vdly = RESP cycle
    // index carrying mem_rvalid (beyond c_TO means no response).
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int rdly, input int vdly, input bit hold_en);
        int          stall_n;
        int          req_n;
        int          bad;
        int          ridx;
        int          exp_stall;
        int          exp_req;
        bit          acc;
        bit          done;
        bit          oor;
        bit          fire;
        bit          f_we;
        logic [31:0] f_addr;
        logic [31:0] f_wd;
        logic [31:0] acc_addr;
        stall_n  = 0;
        req_n    = 0;
        bad      = 0;
        ridx     = 0;
        acc      = 1'b0;
        done     = 1'b0;
        acc_addr = 32'd0;
        oor      = (64'(a) >= 64'(c_DEPTH));
        if (oor) begin
            exp_stall = 1;
            exp_req   = 0;
            m_rd      = 32'd0;
            m_err     = 1'b1;
        end else if (w) begin
            exp_stall = 2 + rdly;
            exp_req   = 1 + rdly;
            ref_mem[a] = d;
        end else begin
            exp_req = 1 + rdly;
            if (vdly <= c_TO) begin
                exp_stall = 2 + rdly + vdly + 1;
                m_rd      = ref_mem.exists(a) ? ref_mem[a] : 32'd0;
            end else begin
                exp_stall = 2 + rdly + c_TO + 1;
                m_rd      = 32'd0;
                m_err     = 1'b1;
            end
        end
        en   = 1'b1;
        we   = w;
        addr = a;
        wd   = d;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            #1;
            fire = 1'b0;
            if (mem_req) begin
                req_n++;
                if (mem_we !== w || mem_addr !== a || mem_wdata !== d) bad++;
                mem_ready = (req_n > rdly);
                fire      = mem_ready;
                f_we      = mem_we;
                f_addr    = mem_addr;
                f_wd      = mem_wdata;
            end else begin
                mem_ready = 1'b0;
            end
            mem_rvalid = acc && (ridx == vdly);
            mem_rdata  = bmem.exists(acc_addr) ? bmem[acc_addr] : 32'd0;
            if (stall) begin
                stall_n++;
            end else begin
                done = 1'b1;
                check("done_rd", rd, m_rd);
                check("done_err", {31'd0, err}, {31'd0, m_err});
            end
            @(posedge clock);
            if (fire) begin
                if (f_we) begin
                    bmem[f_addr] = f_wd;
                end else begin
                    acc      = 1'b1;
                    ridx     = 0;
                    acc_addr = f_addr;
                end
            end else if (acc) begin
                ridx++;
            end
            @(negedge clock);
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
        end
        if (!done) check("access_bound", 32'd1, 32'd0);
        check("stall_cycles", stall_n, exp_stall);
        check("req_cycles", req_n, exp_req);
        check("req_fields", bad, 32'd0);
        if (!hold_en) en = 1'b0;
    endtask

    task automatic pulse_rvalid(input logic [31:0] data);
        en         = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(posedge clock);
        @(negedge clock);
        mem_rvalid = 1'b0;
        #1;
        check("late_rvalid_rd", rd, m_rd);
        check("late_rvalid_stall", {31'd0, stall}, 32'd0);
        check("late_rvalid_req", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic random_run(input int n, input bit allow_oor);
        bit          w;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = 32'(c_DEPTH - 1);
                1:       a = allow_oor ? 32'(c_DEPTH) : 32'd3;
                2:       a = allow_oor ? 32'hFFFF_FFFF : 32'd9;
                default: a = 32'($urandom_range(0, 15));
            endcase
            access(w, a, $urandom, $urandom_range(0, 3), $urandom_range(0, c_TO),
                   (i != n - 1) && ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        reset      = 1'b0;
        en         = 1'b0;
        we         = 1'b0;
        addr       = 32'd0;
        wd         = 32'd0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        m_rd       = 32'd0;
        m_err      = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_rd", rd, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        bmem[32'h10]    = 32'hDEAD_BEEF;
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        access(1'b0, 32'h10, 32'd0, 0, 0, 1'b0);
        pulse_rvalid(32'h0BAD_F00D);

        access(1'b1, 32'd5, 32'h1234_5678, 2, 0, 1'b0);
        access(1'b0, 32'd5, 32'd0, 0, 0, 1'b0);

        random_run(40, 1'b0);

        bmem[32'd20] = 32'hA5A5_0020;  ref_mem[32'd20] = 32'hA5A5_0020;
        bmem[32'd21] = 32'h5A5A_0021;  ref_mem[32'd21] = 32'h5A5A_0021;
        access(1'b0, 32'd20, 32'd0, 0, 0, 1'b1);
        access(1'b0, 32'd21, 32'd0, 0, 0, 1'b0);

        // Reset while a read is waiting in RESP
        en        = 1'b1;
        we        = 1'b0;
        addr      = 32'd21;
        mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        mem_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_rd  = 32'd0;
        m_err = 1'b0;
        #1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_stall_en1", {31'd0, stall}, 32'd1);
        check("rst_mid_rd", rd, 32'd0);
        en = 1'b0;
        #1;
        check("rst_mid_stall_en0", {31'd0, stall}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        pulse_rvalid(32'h5555_AAAA);
        access(1'b0, 32'h10, 32'd0, 1, 2, 1'b0);

        access(1'b0, 32'h0001_0000, 32'd0, 0, 0, 1'b0);
        @(negedge clock);
        #1;
        check("oor_err_sticky", {31'd0, err}, 32'd1);

        access(1'b0, 32'd7, 32'd0, 0, 1000, 1'b0);
        pulse_rvalid(32'hCAFE_F00D);

        random_run(15, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
